demux1to4_32bit_buffered: RTL



---
 rtl/demux1to4_32bit_buffered.sv | 106 ++++++++++
 1 files changed

// File: rtl/demux1to4_32bit_buffered.sv
// One-to-four routing demux: a single valid/ready input stream is steered by
// in_select into one of four independent DEPTH-entry FIFOs, each with its own handshake.

module demux_chan_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rdy,
    output logic             full,
    output logic             vld,
    output logic [WIDTH-1:0] rdata
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rptr, wptr;
    logic [CW-1:0]    count;
    logic             pop;

    assign vld   = (count != '0);
    assign full  = (count == FULL_CNT);
    assign pop   = vld && rdy;
    // Gate the head so stale storage never leaks out of an empty channel.
    assign rdata = vld ? mem[rptr] : '0;

    // Storage is intentionally not reset; occupancy gating hides it.
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module demux1to4_32bit_buffered #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       in_select,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic             busy
);
    localparam int NUM_LANES = 4;

    logic [NUM_LANES-1:0]            full;
    logic [NUM_LANES-1:0]            push;
    logic [NUM_LANES-1:0][WIDTH-1:0] head;

    // A full channel refuses even if it pops this cycle: no pass-through path.
    assign in_ready = !rst && !full[in_select];

    genvar i;
    generate
        for (i = 0; i < NUM_LANES; i++) begin : g_chan
            assign push[i] = in_valid && in_ready && (in_select == 2'(i));
            demux_chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_chan (
                .clk   (clk),
                .rst   (rst),
                .push  (push[i]),
                .wdata (in_data),
                .rdy   (out_ready[i]),
                .full  (full[i]),
                .vld   (out_valid[i]),
                .rdata (head[i])
            );
        end
    endgenerate

    assign out_data0 = head[0];
    assign out_data1 = head[1];
    assign out_data2 = head[2];
    assign out_data3 = head[3];
    assign busy      = |out_valid;
endmodule
